actor_step_sequencer: RTL and testbench
=======================================

// Module: actor_step_sequencer
// PURPOSE
//  Parametrised successor to the one-hot step controller. Adds an advance
//  strobe, absolute jump, a wrap or saturate end policy, a step-index output
//  and an iteration counter.
//  Sits beside each actor datapath and sequences multi-cycle evaluation steps.
// PARAMETERS
//  STEP_COUNT   5  number of steps; one-hot state width (>=1)
//  NEXT_LENGTH  3  width of 'next' shift amount
//  IDX_WIDTH    3  width of index ports; must satisfy 2**IDX_WIDTH >= STEP_COUNT
//  ITER_WIDTH   8  width of iteration (wrap) counter
//  WRAP_MODE    1  1: wrap past last step to step 0; 0: saturate at last step
// PORTS
//  clock       in   1            rising-edge clock
//  reset       in   1            asynchronous, active-high reset
//  advance     in   1            apply 'next' this cycle
//  next        in   NEXT_LENGTH  steps to move forward (0 = stay)
//  jump        in   1            load jump_index this cycle
//  jump_index  in   IDX_WIDTH    absolute target step
//  state       out  STEP_COUNT   one-hot current step, registered
//  step_index  out  IDX_WIDTH    binary index of current step, registered
//  at_last     out  1            current step == STEP_COUNT-1
//  wrapped     out  1            1-cycle pulse: last update wrapped or saturated
//  jump_err    out  1            1-cycle pulse: jump_index >= STEP_COUNT
//  iter_count  out  ITER_WIDTH   number of wraps since reset (mod 2**ITER_WIDTH)
//  onehot_err  out  1            sticky illegal-state flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: applies asynchronously on assertion of reset and holds while reset is high.
//    Values: state=1, step_index=0, at_last=(STEP_COUNT==1), wrapped=0,
//    jump_err=0, iter_count=0, onehot_err=0.
//  - All outputs are registered; an update at edge N is visible after edge N.
//  - Priority each cycle: jump > advance > hold.
//  - Jump with jump_index<STEP_COUNT: the step becomes jump_index.
//    wrapped=0; iter_count is unchanged.
//  - Jump with jump_index>=STEP_COUNT: state holds, jump_err pulses for 1 cycle,
//    and a simultaneous advance is ignored.
//  - Advance: sum = step_index + next, computed in IDX_WIDTH+NEXT_LENGTH+1 bits
//    (no overflow).
//      sum < STEP_COUNT: the step becomes sum; wrapped=0.
//      WRAP_MODE=1, sum>=STEP_COUNT: the step becomes sum mod STEP_COUNT.
//        wrapped=1; iter_count += 1, once per update even when multiple laps occur.
//      WRAP_MODE=0, sum>=STEP_COUNT: the step becomes STEP_COUNT-1.
//        wrapped=1 only if the sum exceeded the last step; iter_count is unchanged.
//  - advance with next=0: the step holds and wrapped=0.
//  - iter_count wraps from all-ones to 0 silently.
//  - STEP_COUNT=1: the step stays 0. at_last=1 always.
//    In WRAP_MODE=1, every advance with next>0 pulses wrapped and increments iter_count.
//  - Reset asserted mid-sequence overrides everything immediately.
//    After reset, the next edge with advance applies normally.
// CONFIGURATION
//  ACTOR_SEQ_ONEHOT_CHECK_EN defined:
//    - Each cycle, state is checked for exactly one bit set.
//    - If the check fails, the next edge forces state=1 and step_index=0.
//    - onehot_err is set and stays high until reset.
//  ACTOR_SEQ_ONEHOT_CHECK_EN undefined:
//    - No checker logic is built.
//    - onehot_err is tied to 0.
// STRUCTURE
//  - Shared package actor_pkg holds:
//    - the index/next width helper function (clog2);
//    - the default STEP_COUNT/NEXT_LENGTH constants;
//    - the wrap-policy localparams ACTOR_WRAP=1 and ACTOR_SAT=0.
//  - One sub-module: actor_onehot_encoder (one-hot -> binary index).
//    It is reused by the checker and by datapath debug.
//  - Next-index arithmetic and the one-hot decode are kept inline.
// TESTING  (STEP_COUNT=5, NEXT_LENGTH=3 unless stated)
//  1. Reset high mid-run at step 3 -> state=5'b00001 asynchronously, iter_count=0.
//     Release, then advance next=1 -> state=5'b00010.
//  2. WRAP_MODE=1, step 3, advance next=4 -> step 2, wrapped=1 for 1 cycle,
//     iter_count=1.
//  3. WRAP_MODE=0, step 3, advance next=4 -> step 4, wrapped=1.
//     Then advance next=1 at step 4 -> stays 4, wrapped=1, iter_count=0.
//  4. jump=1, jump_index=6 together with advance next=1 at step 1 -> stays 1, jump_err=1.
//     Then jump_index=4 -> step 4, at_last=1.
//  5. STEP_COUNT=1, WRAP_MODE=1: 300 advances with next=1 -> state=1 throughout,
//     iter_count=44 (300 mod 256).
//  6. With ACTOR_SEQ_ONEHOT_CHECK_EN: force state=5'b00110 -> next edge state=5'b00001,
//     onehot_err=1 held until reset.

Source files
------------

// File: rtl/actor_pkg.sv
// Shared constants and helpers for the actor step sequencer.
// Holds width helper, default sizing and the wrap/saturate policy codes.
package actor_pkg;

  localparam int ACTOR_STEP_COUNT  = 5;
  localparam int ACTOR_NEXT_LENGTH = 3;

  localparam int ACTOR_WRAP = 1;
  localparam int ACTOR_SAT  = 0;

  function automatic int actor_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // An index port is never narrower than one bit, even for a single step.
  function automatic int actor_idx_width(input int n);
    return (actor_clog2(n) < 1) ? 1 : actor_clog2(n);
  endfunction

endpackage

// File: rtl/actor_onehot_encoder.sv
// One-hot to binary index encoder (OR-reduction of set-bit positions).
// Shared by the step sequencer checker and datapath debug taps.
module actor_onehot_encoder
  import actor_pkg::*;
#(
  parameter int N = ACTOR_STEP_COUNT,
  parameter int W = actor_idx_width(ACTOR_STEP_COUNT)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) index = index | W'(i);
    end
  end

endmodule

// File: rtl/actor_step_sequencer.sv
// One-hot step sequencer with advance, jump, wrap/saturate and iteration count.
// Optional one-hot integrity checker: define ACTOR_SEQ_ONEHOT_CHECK_EN.
module actor_step_sequencer
  import actor_pkg::*;
#(
  parameter int STEP_COUNT  = ACTOR_STEP_COUNT,
  parameter int NEXT_LENGTH = ACTOR_NEXT_LENGTH,
  parameter int IDX_WIDTH   = actor_idx_width(ACTOR_STEP_COUNT),
  parameter int ITER_WIDTH  = 8,
  parameter int WRAP_MODE   = ACTOR_WRAP
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   advance,
  input  logic [NEXT_LENGTH-1:0] next,
  input  logic                   jump,
  input  logic [IDX_WIDTH-1:0]   jump_index,
  output logic [STEP_COUNT-1:0]  state,
  output logic [IDX_WIDTH-1:0]   step_index,
  output logic                   at_last,
  output logic                   wrapped,
  output logic                   jump_err,
  output logic [ITER_WIDTH-1:0]  iter_count,
  output logic                   onehot_err
);

  localparam int SUMW = IDX_WIDTH + NEXT_LENGTH + 1;
  localparam logic [SUMW-1:0] COUNT = SUMW'(STEP_COUNT);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(STEP_COUNT - 1);
  localparam logic [STEP_COUNT-1:0] FIRST = STEP_COUNT'(1);
  localparam logic AT_LAST_RST = (STEP_COUNT == 1);

  logic [STEP_COUNT-1:0] state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  at_last_q, at_last_d;
  logic                  wrapped_q, wrapped_d;
  logic                  jump_err_q, jump_err_d;
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic [IDX_WIDTH-1:0]  cur_idx, next_idx;
  logic [SUMW-1:0]       sum, jump_ext;

  actor_onehot_encoder #(
    .N (STEP_COUNT),
    .W (IDX_WIDTH)
  ) u_enc (
    .onehot (state_q),
    .index  (cur_idx)
  );

`ifdef ACTOR_SEQ_ONEHOT_CHECK_EN
  logic onehot_err_q, onehot_err_d;
  logic onehot_ok;

  // Re-encoding the decoded index reproduces state only for a legal one-hot.
  assign onehot_ok = (state_q == (FIRST << cur_idx));
`endif

  always_comb begin
    sum        = SUMW'(cur_idx) + SUMW'(next);
    jump_ext   = SUMW'(jump_index);
    next_idx   = cur_idx;
    wrapped_d  = 1'b0;
    jump_err_d = 1'b0;
    iter_d     = iter_q;
    if (jump) begin
      if (jump_ext < COUNT) next_idx = jump_index;
      else jump_err_d = 1'b1;
    end else if (advance) begin
      if (sum < COUNT) begin
        next_idx = IDX_WIDTH'(sum);
      end else if (WRAP_MODE == ACTOR_WRAP) begin
        next_idx  = IDX_WIDTH'(sum % COUNT);
        wrapped_d = 1'b1;
        iter_d    = iter_q + ITER_WIDTH'(1);
      end else begin
        next_idx  = LAST_IDX;
        wrapped_d = 1'b1;
      end
    end
    idx_d     = next_idx;
    state_d   = FIRST << next_idx;
    at_last_d = (next_idx == LAST_IDX);
`ifdef ACTOR_SEQ_ONEHOT_CHECK_EN
    onehot_err_d = onehot_err_q | ~onehot_ok;
    if (!onehot_ok) begin
      idx_d      = '0;
      state_d    = FIRST;
      at_last_d  = AT_LAST_RST;
      wrapped_d  = 1'b0;
      jump_err_d = 1'b0;
      iter_d     = iter_q;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FIRST;
      idx_q      <= '0;
      at_last_q  <= AT_LAST_RST;
      wrapped_q  <= 1'b0;
      jump_err_q <= 1'b0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      at_last_q  <= at_last_d;
      wrapped_q  <= wrapped_d;
      jump_err_q <= jump_err_d;
      iter_q     <= iter_d;
    end
  end

`ifdef ACTOR_SEQ_ONEHOT_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) onehot_err_q <= 1'b0;
    else onehot_err_q <= onehot_err_d;
  end

  assign onehot_err = onehot_err_q;
`else
  assign onehot_err = 1'b0;
`endif

  assign state      = state_q;
  assign step_index = idx_q;
  assign at_last    = at_last_q;
  assign wrapped    = wrapped_q;
  assign jump_err   = jump_err_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_actor_step_sequencer.sv
// Scoreboard bench: three sequencer configs share random/directed stimulus.
// Expected responses come from a step/iteration reference model.
module tb_actor_step_sequencer;

  typedef struct packed {
    logic [4:0] st;
    logic [2:0] ix;
    logic       al;
    logic       w;
    logic       je;
    logic [7:0] it;
    logic       oe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       adv = 1'b0;
  logic       jmp = 1'b0;
  logic [2:0] nxt = '0;
  logic [2:0] jidx = '0;

  logic [4:0] st0, st1;
  logic [0:0] st2;
  logic [2:0] ix0, ix1;
  logic [0:0] ix2;
  logic       al0, al1, al2, w0, w1, w2, je0, je1, je2, oe0, oe1, oe2;
  logic [7:0] it0, it1, it2;

  always #5 clk = ~clk;

  actor_step_sequencer #(
    .STEP_COUNT(5), .NEXT_LENGTH(3), .IDX_WIDTH(3),
    .ITER_WIDTH(8), .WRAP_MODE(1)
  ) dut0 (
    .clock(clk), .reset(rst), .advance(adv), .next(nxt),
    .jump(jmp), .jump_index(jidx), .state(st0), .step_index(ix0),
    .at_last(al0), .wrapped(w0), .jump_err(je0),
    .iter_count(it0), .onehot_err(oe0)
  );

  actor_step_sequencer #(
    .STEP_COUNT(5), .NEXT_LENGTH(3), .IDX_WIDTH(3),
    .ITER_WIDTH(8), .WRAP_MODE(0)
  ) dut1 (
    .clock(clk), .reset(rst), .advance(adv), .next(nxt),
    .jump(jmp), .jump_index(jidx), .state(st1), .step_index(ix1),
    .at_last(al1), .wrapped(w1), .jump_err(je1),
    .iter_count(it1), .onehot_err(oe1)
  );

  actor_step_sequencer #(
    .STEP_COUNT(1), .NEXT_LENGTH(3), .IDX_WIDTH(1),
    .ITER_WIDTH(8), .WRAP_MODE(1)
  ) dut2 (
    .clock(clk), .reset(rst), .advance(adv), .next(nxt),
    .jump(jmp), .jump_index(jidx[0:0]), .state(st2), .step_index(ix2),
    .at_last(al2), .wrapped(w2), .jump_err(je2),
    .iter_count(it2), .onehot_err(oe2)
  );

  int tests = 0;
  int fails = 0;

  exp_t sb[3][$];
  int   step[3];
  int   iter[3];
  bit   oerr[3];
  int   sc[3] = '{5, 5, 1};
  bit   wm[3] = '{1'b1, 1'b0, 1'b1};

  function automatic exp_t snap(int d, bit w, bit je);
    exp_t e;
    e.st = 5'(1 << step[d]);
    e.ix = 3'(step[d]);
    e.al = (step[d] == sc[d] - 1);
    e.w  = w;
    e.je = je;
    e.it = 8'(iter[d]);
    e.oe = oerr[d];
    return e;
  endfunction

  function automatic exp_t obs(int d);
    exp_t e;
    case (d)
      0: e = '{st0, ix0, al0, w0, je0, it0, oe0};
      1: e = '{st1, ix1, al1, w1, je1, it1, oe1};
      default: e = '{{4'b0, st2}, {2'b0, ix2}, al2, w2, je2, it2, oe2};
    endcase
    return e;
  endfunction

  task automatic check(string nm, exp_t act, exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual st=%b ix=%0d al=%b w=%b je=%b it=%0d oe=%b required st=%b ix=%0d al=%b w=%b je=%b it=%0d oe=%b",
               nm, act.st, act.ix, act.al, act.w, act.je, act.it, act.oe,
               exp.st, exp.ix, exp.al, exp.w, exp.je, exp.it, exp.oe);
    end
  endtask

  // Step rules: jump beats advance; laps count once per update.
  task automatic model(int d, bit a, int n, bit j, int ji, output exp_t e);
    bit w, je;
    int s, jv;
    w  = 0;
    je = 0;
    jv = (d == 2) ? ji % 2 : ji;
    if (j) begin
      if (jv < sc[d]) step[d] = jv;
      else je = 1;
    end else if (a) begin
      s = step[d] + n;
      if (s < sc[d]) begin
        step[d] = s;
      end else if (wm[d]) begin
        step[d] = s % sc[d];
        w = 1;
        iter[d] = (iter[d] + 1) % 256;
      end else begin
        step[d] = sc[d] - 1;
        w = 1;
      end
    end
    e = snap(d, w, je);
  endtask

  task automatic drive(bit a, int n, bit j, int ji);
    exp_t e;
    @(negedge clk);
    adv  = a;
    nxt  = 3'(n);
    jmp  = j;
    jidx = 3'(ji);
    for (int d = 0; d < 3; d++) begin
      model(d, a, n, j, ji, e);
      sb[d].push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      step[d] = 0;
      iter[d] = 0;
      oerr[d] = 0;
      sb[d].delete();
    end
  endtask

  // Reset lands between edges to exercise its asynchronous path.
  task automatic do_reset(string nm);
    @(posedge clk);
    #3;
    adv = 0;
    jmp = 0;
    rst = 1;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) check(nm, obs(d), snap(d, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        for (int d = 0; d < 3; d++) begin
          if (sb[d].size() > 0) begin
            e = sb[d].pop_front();
            check($sformatf("dut%0d_step", d), obs(d), e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) check("reset_initial", obs(d), snap(d, 0, 0));
    @(negedge clk);
    rst = 0;

    drive(1, 2, 0, 0);
    drive(0, 0, 1, 3);
    do_reset("reset_midrun");
    drive(1, 1, 0, 0);

    drive(0, 0, 1, 3);
    drive(1, 4, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);

    drive(0, 0, 1, 1);
    drive(1, 1, 1, 6);
    drive(0, 0, 1, 4);
    drive(1, 7, 0, 0);
    drive(0, 0, 0, 0);

    do_reset("reset_before_laps");
    repeat (300) drive(1, 1, 0, 0);

`ifdef ACTOR_SEQ_ONEHOT_CHECK_EN
    begin
      exp_t e;
      @(negedge clk);
      adv = 0;
      jmp = 0;
      step[0] = 0;
      oerr[0] = 1;
      sb[0].push_back(snap(0, 0, 0));
      for (int d = 1; d < 3; d++) begin
        model(d, 0, 0, 0, 0, e);
        sb[d].push_back(e);
      end
      force dut0.state_q = 5'b00110;
      #1;
      release dut0.state_q;
    end
    repeat (20) drive(1, 3, 0, 0);
`endif

    repeat (700) begin
      drive($urandom_range(1, 0), $urandom_range(7, 0),
            ($urandom_range(4, 0) == 0), $urandom_range(7, 0));
    end
    do_reset("reset_random");
    repeat (700) begin
      drive($urandom_range(1, 0), $urandom_range(7, 0),
            ($urandom_range(5, 0) == 0), $urandom_range(7, 0));
    end

    @(negedge clk);
    adv = 0;
    jmp = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (sb[d].size() != 0) begin
        fails++;
        $display("FAIL drain dut%0d actual %0d pending required 0", d, sb[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
